// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter signal bundle for uart_tx_arbiter.
// slave = arbiter side, master = requesters plus transmitter side.
interface uart_tx_arbiter_if #(
   parameter int p_num_ch = 4
);
   logic [p_num_ch-1:0]   req_valid_i;
   logic [8*p_num_ch-1:0] req_data_i;
   logic [p_num_ch-1:0]   req_ready_o;
   logic [p_num_ch-1:0]   grant_o;
   logic                  tx_enable_o;
   logic [7:0]            tx_data_o;
   logic                  tx_busy_i;
   logic                  tx_done_o;

   modport slave (
      input  req_valid_i, req_data_i, tx_busy_i,
      output req_ready_o, grant_o, tx_enable_o,
      output tx_data_o, tx_done_o
   );

   modport master (
      output req_valid_i, req_data_i, tx_busy_i,
      input  req_ready_o, grant_o, tx_enable_o,
      input  tx_data_o, tx_done_o
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from p_num_ch channels.
// Define UART_ARB_TAG_EN to prefix each byte with tag {5'b10100, ch}.
module uart_tx_arbiter #(
   parameter int p_num_ch = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   uart_tx_arbiter_if.slave bus
);
`ifdef UART_ARB_TAG_EN
   typedef enum logic [2:0] {
      S_IDLE, S_START, S_WAIT, S_TAG_START, S_TAG_WAIT
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE, S_START, S_WAIT
   } state_t;
`endif

   state_t              r_state, w_state_nxt;
   logic [2:0]          r_last, w_last_nxt;
   logic [p_num_ch-1:0] r_grant, w_grant_nxt;
   logic [7:0]          r_data, w_data_nxt;
   logic                r_done, w_done_nxt;
   logic [2:0]          w_sel;
   logic [3:0]          w_k;
   logic                w_any;
   logic                w_accept;
   logic                w_en;
   logic [7:0]          w_v8;
   logic [7:0]          w_oh8;
   logic [7:0]          w_bytes [8];
   logic [p_num_ch-1:0] w_ready;
`ifdef UART_ARB_TAG_EN
   logic [7:0]          r_hold, w_hold_nxt;
`endif

   // pad channels out to 8 so selects use a plain 3-bit index
   for (genvar g = 0; g < 8; g++) begin : g_pad
      if (g < p_num_ch) begin : g_ch
         assign w_v8[g]    = bus.req_valid_i[g];
         assign w_bytes[g] = bus.req_data_i[8*g +: 8];
      end else begin : g_none
         assign w_v8[g]    = 1'b0;
         assign w_bytes[g] = 8'h00;
      end
   end

   // scan farthest-to-nearest so the nearest valid after r_last wins
   always_comb begin
      w_any = 1'b0;
      w_sel = '0;
      w_k   = '0;
      for (int i = 8; i >= 1; i--) begin
         if (i <= p_num_ch) begin
            w_k = {1'b0, r_last} + 4'(i);
            if (w_k >= 4'(p_num_ch)) w_k = w_k - 4'(p_num_ch);
            if (w_v8[w_k[2:0]]) begin
               w_any = 1'b1;
               w_sel = w_k[2:0];
            end
         end
      end
   end

   assign w_oh8    = 8'b1 << w_sel;
   assign w_accept = (r_state == S_IDLE) && !bus.tx_busy_i && w_any;
   assign w_ready  = w_accept ? p_num_ch'(w_oh8) : '0;

   always_comb begin
      w_state_nxt = r_state;
      w_last_nxt  = r_last;
      w_grant_nxt = r_grant;
      w_data_nxt  = r_data;
      w_done_nxt  = 1'b0;
      w_en        = 1'b0;
`ifdef UART_ARB_TAG_EN
      w_hold_nxt  = r_hold;
`endif
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_last_nxt  = w_sel;
               w_grant_nxt = w_ready;
`ifdef UART_ARB_TAG_EN
               w_data_nxt  = {5'b10100, w_sel};
               w_hold_nxt  = w_bytes[w_sel];
               w_state_nxt = S_TAG_START;
`else
               w_data_nxt  = w_bytes[w_sel];
               w_state_nxt = S_START;
`endif
            end
         end
         S_START: begin
            w_en = !bus.tx_busy_i;
            if (bus.tx_busy_i) w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (!bus.tx_busy_i) begin
               w_done_nxt  = 1'b1;
               w_grant_nxt = '0;
               w_state_nxt = S_IDLE;
            end
         end
`ifdef UART_ARB_TAG_EN
         S_TAG_START: begin
            w_en = !bus.tx_busy_i;
            if (bus.tx_busy_i) w_state_nxt = S_TAG_WAIT;
         end
         S_TAG_WAIT: begin
            if (!bus.tx_busy_i) begin
               w_data_nxt  = r_hold;
               w_state_nxt = S_START;
            end
         end
`endif
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_last  <= 3'(p_num_ch - 1);
         r_grant <= '0;
         r_data  <= 8'hFF;
         r_done  <= 1'b0;
`ifdef UART_ARB_TAG_EN
         r_hold  <= 8'h00;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_last  <= w_last_nxt;
         r_grant <= w_grant_nxt;
         r_data  <= w_data_nxt;
         r_done  <= w_done_nxt;
`ifdef UART_ARB_TAG_EN
         r_hold  <= w_hold_nxt;
`endif
      end
   end

   assign bus.req_ready_o = w_ready;
   assign bus.grant_o     = r_grant;
   assign bus.tx_enable_o = w_en;
   assign bus.tx_data_o   = r_data;
   assign bus.tx_done_o   = r_done;
endmodule
